bram_port_arbiter: RTL and testbench

//  Shares BRAM data port B between the RS5 data interface and a DMA master (UART loader / copy engine).
//  - CPU has default priority.
//  - A wait counter bounds DMA starvation.
//  - A lock input gives the DMA bounded bursts.
//  - CPU read data is held across stalls, so the core's 1-cycle-late sampling stays correct.

---
 rtl/bram_port_arbiter.sv | 109 ++++++++++
 tb/tb_bram_port_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port B between the CPU data interface and a DMA master.
// CPU has default priority, with bounded DMA starvation and lockable DMA bursts.
module bram_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en_i,
  input  logic [3:0]        cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic [3:0]        dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  input  logic              dma_lock_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_data_o,
  output logic              mem_en_o,
  output logic [3:0]        mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {CPU_OWN, DMA_OWN} state_t;

  state_t            state;
  logic [WW-1:0]     wait_cnt;
  logic [BW-1:0]     burst_cnt;
  logic              cpu_rd_q;
  logic              dma_rd_q;
  logic [DATA_W-1:0] hold_q;
  logic              dma_gnt;
  logic              cpu_gnt;

  // Grants are purely combinational so a request is serviced in the cycle it appears.
  always_comb begin
    dma_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (!reset) begin
      dma_gnt = dma_req_i && (state == DMA_OWN || !cpu_en_i || wait_cnt == WAIT_SAT);
      cpu_gnt = cpu_en_i && !dma_gnt;
    end
  end

  always_comb begin
    mem_en_o   = dma_gnt || cpu_gnt;
    mem_we_o   = 4'h0;
    mem_addr_o = cpu_addr_i;
    mem_data_o = cpu_data_i;
    if (dma_gnt) begin
      mem_we_o   = dma_we_i;
      mem_addr_o = dma_addr_i;
      mem_data_o = dma_data_i;
    end else if (cpu_gnt) begin
      mem_we_o = cpu_we_i;
    end
    cpu_stall_o  = !reset && cpu_en_i && !cpu_gnt;
    dma_gnt_o    = dma_gnt;
    dma_rvalid_o = dma_rd_q;
    dma_data_o   = mem_data_i;
    cpu_data_o   = cpu_rd_q ? mem_data_i : hold_q;
  end

  // The hold register keeps the CPU's last read word visible while DMA owns the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CPU_OWN;
      wait_cnt  <= '0;
      burst_cnt <= '0;
      cpu_rd_q  <= 1'b0;
      dma_rd_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      if (dma_gnt && dma_lock_i && burst_cnt < BURST_LAST) begin
        state     <= DMA_OWN;
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        state     <= CPU_OWN;
        burst_cnt <= '0;
      end

      if (dma_gnt || !dma_req_i) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      cpu_rd_q <= cpu_gnt && (cpu_we_i == 4'h0);
      dma_rd_q <= dma_gnt && (dma_we_i == 4'h0);
      if (cpu_rd_q) begin
        hold_q <= mem_data_i;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a 1-cycle-latency BRAM model.
// Inputs change 1 time unit after each rising edge; outputs are checked 3 units after it.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_lock;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] bram [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_WAIT(8), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_en_i(cpu_en), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
    .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_data_i(dma_wdata),
    .dma_lock_i(dma_lock), .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid), .dma_data_o(dma_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata)
  );

  // Read-first BRAM with byte enables, word-indexed by address bits [11:2].
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) bram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= bram[mem_addr[11:2]];
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] <= 32'h0;
    #0;
    bram[10'h040] <= 32'hDEADBEEF;
    bram[10'h080] <= 32'h12345678;
    bram[10'h0C0] <= 32'hA5A5A5A5;
    for (int k = 0; k < 6; k++) bram[10'h100 + k] <= 32'h1000 + k;
  end

  task automatic applyStimulus(input logic rst, input logic ce, input logic [3:0] cwe,
                               input logic [31:0] caddr, input logic [31:0] cdat,
                               input logic dreq, input logic [3:0] dwe,
                               input logic [31:0] daddr, input logic [31:0] ddat,
                               input logic dlock);
    @(posedge clk);
    #1;
    reset     = rst;
    cpu_en    = ce;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cdat;
    dma_req   = dreq;
    dma_we    = dwe;
    dma_addr  = daddr;
    dma_wdata = ddat;
    dma_lock  = dlock;
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 4'h0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_lock = 1'b0;

    $display("[TB] reset with both requesters active");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 4'hF, 32'h100, 32'h0BAD0BAD, 1, 4'h0, 32'h300, 32'h0, 0);
      checkOutput("rst_mem_en", mem_en, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_stall", cpu_stall, 0);
      checkOutput("rst_gnt", dma_gnt, 0);
    end
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h300, 32'h0, 0);
    checkOutput("rel_cpu_en", mem_en, 1);
    checkOutput("rel_addr", mem_addr, 32'h100);
    checkOutput("rel_gnt", dma_gnt, 0);
    checkOutput("rel_stall", cpu_stall, 0);

    $display("[TB] CPU-only read");
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("rd_mem_en", mem_en, 1);
    checkOutput("rd_addr", mem_addr, 32'h100);
    checkOutput("rd_stall", cpu_stall, 0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("rd_data", cpu_rdata, 32'hDEADBEEF);

    $display("[TB] starvation bound");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h300, 32'h0, 0);
      checkOutput($sformatf("starve_gnt_%0d", i), dma_gnt, (i == 8) ? 1 : 0);
      checkOutput($sformatf("starve_stall_%0d", i), cpu_stall, (i == 8) ? 1 : 0);
      checkOutput($sformatf("starve_addr_%0d", i), mem_addr, (i == 8) ? 32'h300 : 32'h100);
      if (i == 9) begin
        checkOutput("starve_rvalid", dma_rvalid, 1);
        checkOutput("starve_dma_data", dma_rdata, 32'hA5A5A5A5);
        checkOutput("starve_cpu_hold", cpu_rdata, 32'hDEADBEEF);
      end
    end
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    $display("[TB] locked DMA burst");
    applyStimulus(0, 0, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h400, 32'h0, 1);
    checkOutput("b1_gnt", dma_gnt, 1);
    checkOutput("b1_stall", cpu_stall, 0);
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h404, 32'h0, 1);
    checkOutput("b2_gnt", dma_gnt, 1);
    checkOutput("b2_stall", cpu_stall, 1);
    checkOutput("b2_rvalid", dma_rvalid, 1);
    checkOutput("b2_rdata", dma_rdata, 32'h1000);
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h408, 32'h0, 1);
    checkOutput("b3_gnt", dma_gnt, 1);
    checkOutput("b3_stall", cpu_stall, 1);
    checkOutput("b3_rdata", dma_rdata, 32'h1001);
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h40C, 32'h0, 1);
    checkOutput("b4_gnt", dma_gnt, 1);
    checkOutput("b4_stall", cpu_stall, 1);
    applyStimulus(0, 1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h410, 32'h0, 1);
    checkOutput("bcpu_gnt", dma_gnt, 0);
    checkOutput("bcpu_stall", cpu_stall, 0);
    checkOutput("bcpu_addr", mem_addr, 32'h100);
    checkOutput("bcpu_rvalid", dma_rvalid, 1);
    checkOutput("bcpu_rdata", dma_rdata, 32'h1003);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h410, 32'h0, 1);
    checkOutput("b5_gnt", dma_gnt, 1);
    checkOutput("b5_rvalid", dma_rvalid, 0);
    checkOutput("b5_cpu_data", cpu_rdata, 32'hDEADBEEF);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h414, 32'h0, 1);
    checkOutput("b6_gnt", dma_gnt, 1);
    checkOutput("b6_rdata", dma_rdata, 32'h1004);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("bend_rvalid", dma_rvalid, 1);
    checkOutput("bend_rdata", dma_rdata, 32'h1005);
    checkOutput("bend_cpu_hold", cpu_rdata, 32'hDEADBEEF);

    $display("[TB] CPU read then DMA write");
    applyStimulus(0, 1, 4'h0, 32'h200, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h300, 32'hCAFEF00D, 0);
    checkOutput("w_gnt", dma_gnt, 1);
    checkOutput("w_mem_we", mem_we, 4'hF);
    checkOutput("w_cpu_data1", cpu_rdata, 32'h12345678);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("w_cpu_data2", cpu_rdata, 32'h12345678);
    checkOutput("w_rvalid", dma_rvalid, 0);
    applyStimulus(0, 1, 4'h0, 32'h300, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("w_readback", cpu_rdata, 32'hCAFEF00D);

    $display("[TB] reset mid-burst");
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h400, 32'h0, 1);
    checkOutput("mr_b1_gnt", dma_gnt, 1);
    applyStimulus(1, 1, 4'h0, 32'h200, 32'h0, 1, 4'h0, 32'h404, 32'h0, 1);
    checkOutput("mr_rst_gnt", dma_gnt, 0);
    checkOutput("mr_rst_en", mem_en, 0);
    checkOutput("mr_rst_stall", cpu_stall, 0);
    applyStimulus(0, 1, 4'h0, 32'h200, 32'h0, 1, 4'h0, 32'h404, 32'h0, 1);
    checkOutput("mr_cpu_first", dma_gnt, 0);
    checkOutput("mr_cpu_stall", cpu_stall, 0);
    checkOutput("mr_cpu_addr", mem_addr, 32'h200);
    checkOutput("mr_rvalid", dma_rvalid, 0);
    checkOutput("mr_hold_clr", cpu_rdata, 32'h0);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h404, 32'h0, 1);
    checkOutput("mr_b2_gnt", dma_gnt, 1);
    checkOutput("mr_cpu_data", cpu_rdata, 32'h12345678);
    applyStimulus(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    checkOutput("mr_b2_rdata", dma_rdata, 32'h1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
